// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings, FSM states
// and the architectural results for divide-by-zero and signed overflow.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;
    localparam logic [DIV_WIDTH-1:0] DIV_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the new quotient bit when no borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;

    // Extra top bit turns a negative trial difference into a visible borrow.
    assign w_shift  = {rem, quo[WIDTH-1]};
    assign w_diff   = w_shift - {2'b00, divisor};
    assign w_borrow = w_diff[WIDTH+1];

    assign rem_next = w_borrow ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
    assign quo_next = {quo[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Define DIV_EARLY_EXIT_EN to let divide-by-zero and signed overflow skip CALC.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] L_ZERO_Q = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] L_OVF_Q  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t r_state;
    div_state_t w_state_next;

    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_is_rem;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_special;
    logic [WIDTH-1:0] r_special_val;
    logic [WIDTH-1:0] r_R;

    logic             w_signed;
    logic             w_is_rem;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_val;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_signed;
    logic [WIDTH-1:0] w_rem_signed;
    logic [WIDTH-1:0] w_result;

    assign w_signed  = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    assign w_is_rem  = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    assign w_neg_a   = w_signed & A[WIDTH-1];
    assign w_neg_b   = w_signed & B[WIDTH-1];
    // Negating the most negative value yields the same bits, which is its correct unsigned magnitude.
    assign w_mag_a   = w_neg_a ? (WIDTH'(0) - A) : A;
    assign w_mag_b   = w_neg_b ? (WIDTH'(0) - B) : B;
    assign w_div0    = (B == '0);
    assign w_ovf     = w_signed && (A == L_OVF_Q) && (B == L_ZERO_Q);
    assign w_special = w_div0 | w_ovf;
    assign w_special_val = w_div0 ? (w_is_rem ? A : L_ZERO_Q)
                                  : (w_is_rem ? '0 : L_OVF_Q);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    assign w_quo_signed = (r_sign_a ^ r_sign_b) ? (WIDTH'(0) - w_quo_next) : w_quo_next;
    assign w_rem_signed = r_sign_a ? (WIDTH'(0) - w_rem_next[WIDTH-1:0]) : w_rem_next[WIDTH-1:0];
    assign w_result     = r_special ? r_special_val : (r_is_rem ? w_rem_signed : w_quo_signed);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef DIV_EARLY_EXIT_EN
                    w_state_next = w_special ? ST_FIN : ST_CALC;
`else
                    w_state_next = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (r_count == '0) begin
                    w_state_next = ST_FIN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_div         <= '0;
            r_is_rem      <= 1'b0;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_R           <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count       <= CW'(WIDTH - 1);
                        r_rem         <= '0;
                        r_quo         <= w_mag_a;
                        r_div         <= w_mag_b;
                        r_is_rem      <= w_is_rem;
                        r_sign_a      <= w_neg_a;
                        r_sign_b      <= w_neg_b;
                        r_special     <= w_special;
                        r_special_val <= w_special_val;
`ifdef DIV_EARLY_EXIT_EN
                        if (w_special) begin
                            r_R <= w_special_val;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count - CW'(1);
                    // Result is registered on the final iteration so it is stable through FIN and after.
                    if (r_count == '0) begin
                        r_R <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_FIN);
    assign R    = r_R;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; special-case latency follows DIV_EARLY_EXIT_EN.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] R;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif
    localparam int NORMAL_LAT = 33;

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called #1 after a rising edge with the unit idle; returns in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic busy1);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy1 = busy;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        res = R;
        $display("op=%0d A=%08h B=%08h -> R=%08h latency=%0d", o, a, b, res, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || R !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b R=%08h required busy=0 done=0 R=0", busy, done, R);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] res;
        int lat;
        logic b1;
        run_op(2'b01, 32'd100, 32'd7, res, lat, b1);
        n_checks++;
        if (res !== 32'd14 || lat != NORMAL_LAT) begin
            n_fail++;
            $display("FAIL divu_100_7: R=%08h lat=%0d required R=0000000e lat=%0d", res, lat, NORMAL_LAT);
        end
        n_checks++;
        if (b1 !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL divu_busy: first=%b done_cycle=%b required 1 1", b1, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (R !== 32'd14 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_hold: R=%08h done=%b busy=%b required R=0000000e done=0 busy=0", R, done, busy);
        end
        run_op(2'b11, 32'd100, 32'd7, res, lat, b1);
        n_checks++;
        if (res !== 32'd2 || lat != NORMAL_LAT) begin
            n_fail++;
            $display("FAIL remu_100_7: R=%08h lat=%0d required R=00000002 lat=%0d", res, lat, NORMAL_LAT);
        end
        @(posedge clk); #1;
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, res, lat, b1);
        n_checks++;
        if (res !== 32'h7FFF_FFFC) begin
            n_fail++;
            $display("FAIL divu_large: R=%08h required 7ffffffc", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        logic [31:0] res;
        int lat;
        logic b1;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, res, lat, b1);
        n_checks++;
        if (res !== 32'hFFFF_FFFD || lat != NORMAL_LAT) begin
            n_fail++;
            $display("FAIL div_m7_2: R=%08h lat=%0d required R=fffffffd lat=%0d", res, lat, NORMAL_LAT);
        end
        @(posedge clk); #1;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat, b1);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rem_m7_2: R=%08h required ffffffff", res);
        end
        @(posedge clk); #1;
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, res, lat, b1);
        n_checks++;
        if (res !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_7_m2: R=%08h required fffffffd", res);
        end
        @(posedge clk); #1;
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, res, lat, b1);
        n_checks++;
        if (res !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL rem_7_m2: R=%08h required 00000001", res);
        end
        @(posedge clk); #1;
        run_op(2'b00, 32'h8000_0000, 32'd2, res, lat, b1);
        n_checks++;
        if (res !== 32'hC000_0000) begin
            n_fail++;
            $display("FAIL div_min_2: R=%08h required c0000000", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        int lat;
        logic b1;
        run_op(2'b00, 32'd5, 32'd0, res, lat, b1);
        n_checks++;
        if (res !== 32'hFFFF_FFFF || lat != SPECIAL_LAT) begin
            n_fail++;
            $display("FAIL div_by_zero: R=%08h lat=%0d required R=ffffffff lat=%0d", res, lat, SPECIAL_LAT);
        end
        n_checks++;
        if (b1 !== 1'b1) begin
            n_fail++;
            $display("FAIL div_by_zero_busy: busy=%b required 1", b1);
        end
        @(posedge clk); #1;
        run_op(2'b10, 32'd5, 32'd0, res, lat, b1);
        n_checks++;
        if (res !== 32'd5 || lat != SPECIAL_LAT) begin
            n_fail++;
            $display("FAIL rem_by_zero: R=%08h lat=%0d required R=00000005 lat=%0d", res, lat, SPECIAL_LAT);
        end
        @(posedge clk); #1;
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, res, lat, b1);
        n_checks++;
        if (res !== 32'hFFFF_FFFB) begin
            n_fail++;
            $display("FAIL rem_neg_by_zero: R=%08h required fffffffb", res);
        end
        @(posedge clk); #1;
        run_op(2'b01, 32'd5, 32'd0, res, lat, b1);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL divu_by_zero: R=%08h required ffffffff", res);
        end
        @(posedge clk); #1;
        run_op(2'b11, 32'd5, 32'd0, res, lat, b1);
        n_checks++;
        if (res !== 32'd5) begin
            n_fail++;
            $display("FAIL remu_by_zero: R=%08h required 00000005", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [31:0] res;
        int lat;
        logic b1;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, b1);
        n_checks++;
        if (res !== 32'h8000_0000 || lat != SPECIAL_LAT) begin
            n_fail++;
            $display("FAIL div_overflow: R=%08h lat=%0d required R=80000000 lat=%0d", res, lat, SPECIAL_LAT);
        end
        @(posedge clk); #1;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, b1);
        n_checks++;
        if (res !== 32'h0 || lat != SPECIAL_LAT) begin
            n_fail++;
            $display("FAIL rem_overflow: R=%08h lat=%0d required R=00000000 lat=%0d", res, lat, SPECIAL_LAT);
        end
        @(posedge clk); #1;
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, b1);
        n_checks++;
        if (res !== 32'h0 || lat != NORMAL_LAT) begin
            n_fail++;
            $display("FAIL divu_no_overflow: R=%08h lat=%0d required R=00000000 lat=%0d", res, lat, NORMAL_LAT);
        end
        @(posedge clk); #1;
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, b1);
        n_checks++;
        if (res !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL remu_no_overflow: R=%08h required 80000000", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int first_lat = 0;
        logic [31:0] first_r = '0;
        op = 2'b01; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    first_lat = k;
                    first_r = R;
                end
            end
            if (k == 10) begin
                op = 2'b01; A = 32'd9; B = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        $display("busy-start: dones=%0d first_lat=%0d R=%08h", n_done, first_lat, first_r);
        n_checks++;
        if (n_done != 1 || first_lat != NORMAL_LAT || first_r !== 32'd14) begin
            n_fail++;
            $display("FAIL start_while_busy: dones=%0d lat=%0d R=%08h required 1 %0d 0000000e",
                     n_done, first_lat, first_r, NORMAL_LAT);
        end
        begin
            logic [31:0] res;
            int lat;
            logic b1;
            run_op(2'b01, 32'd100, 32'd7, res, lat, b1);
            op = 2'b01; A = 32'd9; B = 32'd3; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            $display("start in done cycle: busy next cycle=%b", busy);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_in_done_cycle: busy=%b required 0", busy);
            end
            n_done = 0;
            for (int k = 0; k < 40; k++) begin
                if (done === 1'b1) n_done++;
                @(posedge clk); #1;
            end
            n_checks++;
            if (n_done != 0) begin
                n_fail++;
                $display("FAIL done_cycle_start_dropped: dones=%0d required 0", n_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat;
        logic b1;
        int n_done = 0;
        op = 2'b01; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid reset: busy=%b done=%b R=%08h", busy, done, R);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || R !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b done=%b R=%08h required 0 0 00000000", busy, done, R);
        end
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: dones=%0d required 0", n_done);
        end
        run_op(2'b01, 32'd9, 32'd3, res, lat, b1);
        n_checks++;
        if (res !== 32'd3 || lat != NORMAL_LAT) begin
            n_fail++;
            $display("FAIL after_reset_op: R=%08h lat=%0d required R=00000003 lat=%0d", res, lat, NORMAL_LAT);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
